// File: rtl/prism_input_filter_if.sv
// Configuration bus for prism_input_filter.
//   cfg_addr  : register select (0=CTRL, 1=STATUS, 2=LEVEL, 3=reserved)
//   cfg_wr    : single-cycle write strobe
//   cfg_wdata : write data
//   cfg_rdata : combinational read data for cfg_addr
// master drives address/strobe/data, slave returns read data.
interface prism_input_filter_if;
    logic [1:0]  cfg_addr;
    logic        cfg_wr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_addr,
        output cfg_wr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_addr,
        input  cfg_wr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/prism_input_filter.sv
// Per-channel glitch filter and edge detector for the PMOD input path.
// Each channel's filtered level follows raw only after raw has differed from it on L+1
// consecutive edges (L = CTRL filter length); bypassed channels follow raw with one cycle
// of latency. Filtered edges produce single-cycle rise/fall pulses, sticky W1C status bits
// and a registered interrupt.
//
// Optional feature: define PRISM_INPUT_INVERT_EN to enable a per-channel invert mask in
// CTRL[CHANNELS-1+20:20], applied to raw_in_i ahead of the filter.
//
// Ports:
//   clk          : project clock
//   rst_n        : asynchronous active-low reset
//   cfg_if       : register bus (CTRL/STATUS/LEVEL)
//   raw_in_i     : synchronized input pins
//   filt_out_o   : filtered levels
//   rise_pulse_o : one-cycle pulse on filtered 0->1
//   fall_pulse_o : one-cycle pulse on filtered 1->0
//   edge_irq_o   : registered edge interrupt
module prism_input_filter #(
    parameter int unsigned CHANNELS = 7,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prism_input_filter_if.slave   cfg_if,
    input  logic [CHANNELS-1:0]   raw_in_i,
    output logic [CHANNELS-1:0]   filt_out_o,
    output logic [CHANNELS-1:0]   rise_pulse_o,
    output logic [CHANNELS-1:0]   fall_pulse_o,
    output logic                  edge_irq_o
);

    localparam logic [31:0] ChanMask = (32'd1 << CHANNELS) - 32'd1;
    localparam logic [31:0] LenMask  = ((32'd1 << CNT_W) - 32'd1) << 8;
    localparam logic [31:0] IrqMask  = 32'h8000_0000;
`ifdef PRISM_INPUT_INVERT_EN
    localparam logic [31:0] InvMask  = ChanMask << 20;
`else
    localparam logic [31:0] InvMask  = 32'h0;
`endif
    // Only implemented CTRL bits are stored; everything else reads back as 0.
    localparam logic [31:0] CtrlWrMask = ChanMask | LenMask | IrqMask | InvMask;

    logic [31:0]         ctrl_q, ctrl_d;
    logic [CHANNELS-1:0] filt_q, filt_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] st_rise_q, st_rise_d;
    logic [CHANNELS-1:0] st_fall_q, st_fall_d;
    logic                irq_q, irq_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    logic [CNT_W-1:0]    filt_len;
    logic [CHANNELS-1:0] bypass;
    logic                irq_en;
    logic [CHANNELS-1:0] raw_eff;
    logic                wr_ctrl;
    logic                wr_status;
    logic [CHANNELS-1:0] clr_rise;
    logic [CHANNELS-1:0] clr_fall;

    assign filt_len  = ctrl_q[CNT_W+7:8];
    assign bypass    = ctrl_q[CHANNELS-1:0];
    assign irq_en    = ctrl_q[31];
    assign wr_ctrl   = cfg_if.cfg_wr && (cfg_if.cfg_addr == 2'd0);
    assign wr_status = cfg_if.cfg_wr && (cfg_if.cfg_addr == 2'd1);

`ifdef PRISM_INPUT_INVERT_EN
    // Inversion sits ahead of the filter, so toggling the mask is filtered like a pin edge.
    assign raw_eff = raw_in_i ^ ctrl_q[CHANNELS+19:20];
`else
    assign raw_eff = raw_in_i;
`endif

    // Filter: cnt counts prior consecutive differing edges; >= lets a lowered L take effect
    // on the next differing edge even when the counter already exceeds it.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (bypass[i]) begin
                filt_d[i] = raw_eff[i];
            end else if (raw_eff[i] != filt_q[i]) begin
                if (cnt_q[i] >= filt_len) begin
                    filt_d[i] = raw_eff[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise_d   = filt_d & ~filt_q;
        fall_d   = ~filt_d & filt_q;
        clr_rise = wr_status ? cfg_if.cfg_wdata[CHANNELS-1:0] : '0;
        clr_fall = wr_status ? cfg_if.cfg_wdata[CHANNELS+15:16] : '0;
        // Set is OR-ed after the clear so a simultaneous new edge is never lost.
        st_rise_d = (st_rise_q & ~clr_rise) | rise_q;
        st_fall_d = (st_fall_q & ~clr_fall) | fall_q;
        irq_d     = irq_en & ((|st_rise_q) | (|st_fall_q));
        ctrl_d    = wr_ctrl ? (cfg_if.cfg_wdata & CtrlWrMask) : ctrl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            filt_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            st_rise_q <= '0;
            st_fall_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ctrl_q    <= ctrl_d;
            filt_q    <= filt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            st_rise_q <= st_rise_d;
            st_fall_q <= st_fall_d;
            irq_q     <= irq_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cfg_if.cfg_rdata = '0;
        case (cfg_if.cfg_addr)
            2'd0: cfg_if.cfg_rdata = ctrl_q;
            2'd1: begin
                cfg_if.cfg_rdata[CHANNELS-1:0]   = st_rise_q;
                cfg_if.cfg_rdata[CHANNELS+15:16] = st_fall_q;
            end
            2'd2:    cfg_if.cfg_rdata[CHANNELS-1:0] = filt_q;
            default: cfg_if.cfg_rdata = '0;
        endcase
    end

    assign filt_out_o   = filt_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;
    assign edge_irq_o   = irq_q;

endmodule

// File: tb/tb_prism_input_filter.sv
module tb_prism_input_filter;

    typedef struct {
        logic [6:0]  filt;
        logic [6:0]  rise;
        logic [6:0]  fall;
        logic        irq;
        logic [31:0] rdata;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] raw_in;
    logic [6:0] filt_out;
    logic [6:0] rise_pulse;
    logic [6:0] fall_pulse;
    logic       edge_irq;

    prism_input_filter_if bus ();

    prism_input_filter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_if       (bus),
        .raw_in_i     (raw_in),
        .filt_out_o   (filt_out),
        .rise_pulse_o (rise_pulse),
        .fall_pulse_o (fall_pulse),
        .edge_irq_o   (edge_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // Reference model state
`ifdef PRISM_INPUT_INVERT_EN
    localparam logic [31:0] CtrlBits = 32'h87F0_0F7F;
`else
    localparam logic [31:0] CtrlBits = 32'h8000_0F7F;
`endif
    logic [31:0] m_ctrl   = '0;
    logic [6:0]  m_filt   = '0;
    logic [6:0]  m_rise   = '0;
    logic [6:0]  m_fall   = '0;
    logic [6:0]  m_st_r   = '0;
    logic [6:0]  m_st_f   = '0;
    logic        m_irq    = 1'b0;
    int          m_run[7] = '{default: 0};
    logic [6:0]  r        = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the model's view of the outputs after that edge.
    task automatic cycle(input logic [6:0] raw, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wdata);
        exp_t       e;
        logic [6:0] old_filt, eff, inv, clr_r, clr_f, nst_r, nst_f;
        int         len;
        @(negedge clk);
        raw_in        = raw;
        bus.cfg_wr    = wr;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;

        len = int'(m_ctrl[11:8]);
`ifdef PRISM_INPUT_INVERT_EN
        inv = m_ctrl[26:20];
`else
        inv = '0;
`endif
        eff      = raw ^ inv;
        old_filt = m_filt;
        // A level is accepted once it has differed on more than L consecutive edges.
        for (int c = 0; c < 7; c++) begin
            if (m_ctrl[c]) begin
                m_filt[c] = eff[c];
                m_run[c]  = 0;
            end else if (eff[c] == old_filt[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                if (m_run[c] > len) begin
                    m_filt[c] = eff[c];
                    m_run[c]  = 0;
                end
            end
        end
        clr_r  = (wr && addr == 2'd1) ? wdata[6:0] : 7'h0;
        clr_f  = (wr && addr == 2'd1) ? wdata[22:16] : 7'h0;
        nst_r  = (m_st_r & ~clr_r) | m_rise;
        nst_f  = (m_st_f & ~clr_f) | m_fall;
        m_irq  = m_ctrl[31] && ((m_st_r != 0) || (m_st_f != 0));
        m_st_r = nst_r;
        m_st_f = nst_f;
        m_rise = m_filt & ~old_filt;
        m_fall = old_filt & ~m_filt;
        if (wr && addr == 2'd0) m_ctrl = wdata & CtrlBits;

        e.filt = m_filt;
        e.rise = m_rise;
        e.fall = m_fall;
        e.irq  = m_irq;
        case (addr)
            2'd0:    e.rdata = m_ctrl;
            2'd1:    e.rdata = {9'h0, m_st_f, 9'h0, m_st_r};
            2'd2:    e.rdata = {25'h0, m_filt};
            default: e.rdata = 32'h0;
        endcase
        sb.push_back(e);
    endtask

    // Monitor: compare everything the DUT presents just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("filt_out", {25'h0, filt_out}, {25'h0, e.filt});
                chk("rise_pulse", {25'h0, rise_pulse}, {25'h0, e.rise});
                chk("fall_pulse", {25'h0, fall_pulse}, {25'h0, e.fall});
                chk("edge_irq", {31'h0, edge_irq}, {31'h0, e.irq});
                chk("cfg_rdata", bus.cfg_rdata, e.rdata);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] wd;
        logic        wr;
        logic [1:0]  ad;
        rst_n         = 1'b0;
        raw_in        = '0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst filt_out", {25'h0, filt_out}, 32'h0);
        chk("rst rise_pulse", {25'h0, rise_pulse}, 32'h0);
        chk("rst fall_pulse", {25'h0, fall_pulse}, 32'h0);
        chk("rst edge_irq", {31'h0, edge_irq}, 32'h0);
        chk("rst ctrl", bus.cfg_rdata, 32'h0);
        bus.cfg_addr = 2'd1;
        #1;
        chk("rst status", bus.cfg_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // L=0: one-cycle follow and single-cycle rise
        cycle(r, 0, 2, 0);
        r = 7'h01;
        repeat (3) cycle(r, 0, 2, 0);

        // L=3: 3-cycle glitch rejected, 4-cycle pulse accepted
        cycle(r, 1, 0, 32'h0000_0300);
        r[2] = 1'b1;
        repeat (3) cycle(r, 0, 2, 0);
        r[2] = 1'b0;
        repeat (3) cycle(r, 0, 2, 0);
        r[2] = 1'b1;
        repeat (6) cycle(r, 0, 2, 0);

        // irq_en, L=0; clear status, then a fall on ch5 and W1C of it
        cycle(r, 1, 0, 32'h8000_0000);
        cycle(r, 1, 1, 32'hFFFF_FFFF);
        r[5] = 1'b1;
        repeat (4) cycle(r, 0, 1, 0);
        cycle(r, 1, 1, 32'hFFFF_FFFF);
        repeat (2) cycle(r, 0, 1, 0);
        r[5] = 1'b0;
        repeat (4) cycle(r, 0, 1, 0);
        cycle(r, 1, 1, 32'h0020_0000);
        repeat (3) cycle(r, 0, 1, 0);

        // W1C of rise bit 1 on the edge the new ch1 rise sets it
        r[1] = 1'b1;
        cycle(r, 0, 1, 0);
        cycle(r, 1, 1, 32'h0000_0002);
        repeat (2) cycle(r, 0, 1, 0);

        // L=15, ch3 differing 10 cycles, then lower L to 4
        cycle(r, 1, 0, 32'h0000_0F00);
        r[3] = 1'b1;
        repeat (10) cycle(r, 0, 2, 0);
        cycle(r, 1, 0, 32'h0000_0400);
        repeat (3) cycle(r, 0, 2, 0);

        // Bypass ch4 with L=15
        cycle(r, 1, 0, 32'h0000_0F10);
        for (int i = 0; i < 4; i++) begin
            r[4] = ~r[4];
            cycle(r, 0, 2, 0);
        end

        // Invert mask on ch0 with raw 0, L=0
        r = '0;
        cycle(r, 1, 0, 32'h0000_0000);
        repeat (3) cycle(r, 0, 2, 0);
        cycle(r, 1, 0, 32'h0010_0000);
        repeat (3) cycle(r, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) r = r ^ (7'($urandom) & 7'($urandom));
            wr = ($urandom_range(0, 9) == 0);
            ad = 2'($urandom);
            wd = $urandom;
            if (wr && ad == 2'd0 && $urandom_range(0, 1) == 0) wd[11:8] = 4'($urandom_range(0, 3));
            if (wr && ad == 2'd0) wd[6:0] = wd[6:0] & 7'($urandom);
            cycle(r, wr, ad, wd);
        end

        @(negedge clk);
        bus.cfg_wr = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
